// File: rtl/uart_fifo_link.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_fifo_link (+ helper uart_fifo_link_fifo)                 |
// | Description : 16x-oversampled UART receiver and transmitter, each side     |
// |               buffered by a synchronous show-ahead FIFO. The crypter pops  |
// |               RX bytes and pushes TX bytes.                                |
// |               Optional macro UART_LOOPBACK_EN adds a 'loopback' input that |
// |               routes the internal TX line into the RX synchroniser.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

// Synchronous FIFO with wrap-bit pointers; head is visible without a pop.
module uart_fifo_link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is then legal.
  assign w_pop   = pop_i && !w_empty;
  assign w_push  = push_i && (!full_o || w_pop);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign valid_o = !w_empty;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; both pointers move when push and pop coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module uart_fifo_link #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef UART_LOOPBACK_EN
  input  logic                          loopback,
`endif
  input  logic                          rx_stream,
  output logic                          tx_stream,
  input  logic                          rx_pop,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
  output logic                          rx_frame_err,
  input  logic                          err_clear,
  input  logic                          tx_push,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_idle
);
  localparam int   DIV_RAW   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int   DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int   DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic PAR_EN    = (PARITY != 0);
  localparam logic PAR_ODD   = (PARITY == 1);
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);

  // ---------------------------------------------------------------- baud tick
  logic [DIV_W-1:0] div_q;
  logic             w_tick;

  assign w_tick = (div_q == DIV_W'(DIV - 1));

  // Free-running 16x oversampling divider, wraps to 0 on the tick.
  always_ff @(posedge clk) begin
    if (rst || w_tick) div_q <= '0;
    else               div_q <= div_q + DIV_W'(1);
  end

  // ---------------------------------------------------------------- line muxing
  logic w_rx_src;
  logic tx_line_q;

`ifdef UART_LOOPBACK_EN
  assign w_rx_src  = loopback ? tx_line_q : rx_stream;
  assign tx_stream = loopback ? 1'b1 : tx_line_q;
`else
  assign w_rx_src  = rx_stream;
  assign tx_stream = tx_line_q;
`endif

  // ---------------------------------------------------------------- RX path
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchroniser, preset to the idle level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= w_rx_src;
      sync2_q <= sync1_q;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  rx_state_e            rx_state_q;
  logic [3:0]           rx_scnt_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_bad_q;
  logic                 rx_wr_q;
  logic                 rx_frame_err_q;

  // Receiver FSM; every state advances only on baud ticks. Set of the error flag wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q     <= RX_IDLE;
      rx_scnt_q      <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_par_bad_q   <= 1'b0;
      rx_wr_q        <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_wr_q <= 1'b0;
      if (err_clear) rx_frame_err_q <= 1'b0;
      if (w_tick) begin
        case (rx_state_q)
          RX_IDLE: begin
            if (!sync2_q) begin
              rx_state_q <= RX_START;
              rx_scnt_q  <= '0;
            end
          end
          RX_START: begin
            if (rx_scnt_q == 4'd7) begin
              if (sync2_q) begin
                rx_state_q <= RX_IDLE;      // glitch: line back high at mid start bit
              end else begin
                rx_state_q   <= RX_DATA;
                rx_scnt_q    <= '0;
                rx_bit_q     <= '0;
                rx_par_bad_q <= 1'b0;
              end
            end else begin
              rx_scnt_q <= rx_scnt_q + 4'd1;
            end
          end
          RX_DATA: begin
            if (rx_scnt_q == 4'd15) begin
              rx_scnt_q  <= '0;
              rx_shift_q <= {sync2_q, rx_shift_q[DATA_BITS-1:1]};
              rx_bit_q   <= rx_bit_q + 4'd1;
              if (rx_bit_q == BIT_LAST) begin
                if (PAR_EN) rx_state_q <= RX_PARITY;
                else        rx_state_q <= RX_STOP;
              end
            end else begin
              rx_scnt_q <= rx_scnt_q + 4'd1;
            end
          end
          RX_PARITY: begin
            if (rx_scnt_q == 4'd15) begin
              rx_scnt_q    <= '0;
              rx_par_bad_q <= ((^rx_shift_q) ^ sync2_q) != PAR_ODD;
              rx_state_q   <= RX_STOP;
            end else begin
              rx_scnt_q <= rx_scnt_q + 4'd1;
            end
          end
          RX_STOP: begin
            if (rx_scnt_q == 4'd15) begin
              // Leave at mid stop bit so the next start edge is caught with half a bit of margin.
              rx_scnt_q  <= '0;
              rx_state_q <= RX_IDLE;
              if (!sync2_q || rx_par_bad_q) rx_frame_err_q <= 1'b1;
              else                          rx_wr_q        <= 1'b1;
            end else begin
              rx_scnt_q <= rx_scnt_q + 4'd1;
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  logic w_rx_full;
  logic w_rx_drop;
  logic rx_overrun_q;

  uart_fifo_link_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_wr_q),
    .wdata_i (rx_shift_q),
    .pop_i   (rx_pop),
    .rdata_o (rx_data),
    .valid_o (rx_valid),
    .full_o  (w_rx_full),
    .count_o (rx_count)
  );

  assign w_rx_drop = rx_wr_q && w_rx_full && !(rx_pop && rx_valid);

  // Sticky overrun flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)            rx_overrun_q <= 1'b0;
    else if (w_rx_drop) rx_overrun_q <= 1'b1;
    else if (err_clear) rx_overrun_q <= 1'b0;
  end

  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

  // ---------------------------------------------------------------- TX path
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  tx_state_e            tx_state_q;
  logic [4:0]           tx_tcnt_q;
  logic [3:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 w_tx_valid;
  logic                 w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  // The FSM consumes the head in the same cycle it leaves IDLE.
  assign w_tx_pop = (tx_state_q == TX_IDLE) && w_tx_valid;

  uart_fifo_link_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .wdata_i (tx_data),
    .pop_i   (w_tx_pop),
    .rdata_o (w_tx_head),
    .valid_o (w_tx_valid),
    .full_o  (tx_full),
    .count_o (tx_count)
  );

  // Transmitter FSM with a registered serial line; each bit lasts 16 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_line_q <= 1'b1;
          if (w_tx_valid) begin
            tx_shift_q <= w_tx_head;
            tx_par_q   <= (^w_tx_head) ^ PAR_ODD;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            if (tx_tcnt_q == 5'd15) begin
              tx_tcnt_q  <= '0;
              tx_line_q  <= tx_shift_q[0];
              tx_state_q <= TX_DATA;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (tx_tcnt_q == 5'd15) begin
              tx_tcnt_q <= '0;
              tx_bit_q  <= tx_bit_q + 4'd1;
              if (tx_bit_q == BIT_LAST) begin
                if (PAR_EN) begin
                  tx_line_q  <= tx_par_q;
                  tx_state_q <= TX_PARITY;
                end else begin
                  tx_line_q  <= 1'b1;
                  tx_state_q <= TX_STOP;
                end
              end else begin
                tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
                tx_line_q  <= tx_shift_q[1];
              end
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            if (tx_tcnt_q == 5'd15) begin
              tx_tcnt_q  <= '0;
              tx_line_q  <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (tx_tcnt_q == STOP_LAST) begin
              tx_tcnt_q  <= '0;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        default: begin
          tx_line_q  <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_idle = !w_tx_valid && (tx_state_q == TX_IDLE) && tx_line_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_link.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_fifo_link                                            |
// | Description : Directed bench for uart_fifo_link at 160 clocks per bit.     |
// |               Instance u_dut0 uses no parity, u_dut2 uses even parity.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_fifo_link;
  localparam int BITC = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // no-parity instance
  logic       rx0 = 1'b1, rx_pop0 = 1'b0, err_clear0 = 1'b0, tx_push0 = 1'b0;
  logic [7:0] tx_data0 = 8'h00;
  logic       tx0, rx_valid0, rx_ovr0, rx_ferr0, tx_full0, tx_idle0;
  logic [7:0] rx_data0;
  logic [4:0] rx_count0, tx_count0;

  // even-parity instance (TX side unused)
  logic       rx2 = 1'b1, rx_pop2 = 1'b0, err_clear2 = 1'b0, tx_push2 = 1'b0;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx2, rx_valid2, rx_ovr2, rx_ferr2, tx_full2, tx_idle2;
  logic [7:0] rx_data2;
  logic [4:0] rx_count2, tx_count2;

  uart_fifo_link #(
    .CLK_FREQ(100000000), .BAUD_RATE(625000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut0 (
    .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_stream(rx0), .tx_stream(tx0), .rx_pop(rx_pop0), .rx_valid(rx_valid0),
    .rx_data(rx_data0), .rx_count(rx_count0), .rx_overrun(rx_ovr0),
    .rx_frame_err(rx_ferr0), .err_clear(err_clear0), .tx_push(tx_push0),
    .tx_data(tx_data0), .tx_full(tx_full0), .tx_count(tx_count0), .tx_idle(tx_idle0)
  );

  uart_fifo_link #(
    .CLK_FREQ(100000000), .BAUD_RATE(625000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut2 (
    .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_stream(rx2), .tx_stream(tx2), .rx_pop(rx_pop2), .rx_valid(rx_valid2),
    .rx_data(rx_data2), .rx_count(rx_count2), .rx_overrun(rx_ovr2),
    .rx_frame_err(rx_ferr2), .err_clear(err_clear2), .tx_push(tx_push2),
    .tx_data(tx_data2), .tx_full(tx_full2), .tx_count(tx_count2), .tx_idle(tx_idle2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial frame on rx line 'which' (0 or 2); bits[] is LSB-first, start bit included.
  task automatic drive_frame(input int which, input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx0 = bits[i]; else rx2 = bits[i];
      repeat (BITC) @(negedge clk);
    end
    if (which == 0) rx0 = 1'b1; else rx2 = 1'b1;
  endtask

  task automatic pop0();
    rx_pop0 = 1'b1;
    @(negedge clk);
    rx_pop0 = 1'b0;
  endtask

  // Background decoder of tx0: {stop, data} per frame, sampled at mid-bit.
  logic [8:0] txq[$];
  logic [8:0] mon_fr;
  always begin
    @(negedge clk);
    if (!rst && tx0 === 1'b0) begin
      repeat (79) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        repeat (BITC) @(negedge clk);
        mon_fr[i] = tx0;
      end
      txq.push_back(mon_fr);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_head;
    int         exp_count;
    logic       exp_ferr;
  } rxvec_t;

  rxvec_t tbl[5];

  initial begin
    int len, t, w;
    tbl[0] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1, 1'b0};
    tbl[1] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1, 1'b0};
    tbl[2] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 2, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 2, 1'b1};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst tx_stream", tx0, 1);
    chk("rst rx_valid", rx_valid0, 0);
    chk("rst rx_count", rx_count0, 0);
    chk("rst tx_count", tx_count0, 0);
    chk("rst tx_full", tx_full0, 0);
    chk("rst tx_idle", tx_idle0, 1);
    chk("rst overrun", rx_ovr0, 0);
    chk("rst frame_err", rx_ferr0, 0);

    // ---- RX vector table
    for (int v = 0; v < 5; v++) begin
      drive_frame(0, {1'b1, tbl[v].stop, tbl[v].data, 1'b0}, 10);
      repeat (100) @(negedge clk);
      chk($sformatf("vec%0d rx_valid", v), rx_valid0, tbl[v].exp_valid);
      if (tbl[v].exp_valid) chk($sformatf("vec%0d rx_data", v), rx_data0, tbl[v].exp_head);
      chk($sformatf("vec%0d rx_count", v), rx_count0, tbl[v].exp_count);
      chk($sformatf("vec%0d frame_err", v), rx_ferr0, tbl[v].exp_ferr);
      chk($sformatf("vec%0d overrun", v), rx_ovr0, 0);
      if (tbl[v].pop) begin
        pop0();
        chk($sformatf("vec%0d count after pop", v), rx_count0, tbl[v].exp_count - 1);
        chk($sformatf("vec%0d valid after pop", v), rx_valid0, tbl[v].exp_count > 1);
      end
      if (tbl[v].clr) begin
        err_clear0 = 1'b1;
        @(negedge clk);
        err_clear0 = 1'b0;
        chk($sformatf("vec%0d frame_err cleared", v), rx_ferr0, 0);
      end
    end
    chk("tbl tail head", rx_data0, 8'hFF);
    pop0();
    chk("tbl drained", rx_count0, 0);

    // ---- overrun: 17 frames, no pops
    for (int i = 0; i < 17; i++) drive_frame(0, {2'b11, 8'(8'h10 + i), 1'b0}, 10);
    repeat (20) @(negedge clk);
    chk("ovr rx_count", rx_count0, 16);
    chk("ovr overrun", rx_ovr0, 1);
    chk("ovr head", rx_data0, 8'h10);
    chk("ovr frame_err", rx_ferr0, 0);
    err_clear0 = 1'b1;
    @(negedge clk);
    err_clear0 = 1'b0;
    chk("ovr cleared", rx_ovr0, 0);
    chk("ovr count kept", rx_count0, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr drain %0d", i), rx_data0, 8'(8'h10 + i));
      pop0();
    end
    chk("ovr drained", rx_valid0, 0);

    // ---- glitch rejection, then a good frame
    rx0 = 1'b0;
    repeat (40) @(negedge clk);
    rx0 = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch count", rx_count0, 0);
    chk("glitch frame_err", rx_ferr0, 0);
    drive_frame(0, {2'b11, 8'h5A, 1'b0}, 10);
    repeat (20) @(negedge clk);
    chk("post-glitch count", rx_count0, 1);
    chk("post-glitch data", rx_data0, 8'h5A);
    pop0();

    // ---- even parity instance: good, bad, good
    drive_frame(2, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    repeat (100) @(negedge clk);
    chk("par good count", rx_count2, 1);
    chk("par good data", rx_data2, 8'h3C);
    chk("par good err", rx_ferr2, 0);
    drive_frame(2, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    repeat (100) @(negedge clk);
    chk("par bad err", rx_ferr2, 1);
    chk("par bad count", rx_count2, 1);
    drive_frame(2, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (100) @(negedge clk);
    chk("par odd-pop count", rx_count2, 2);
    chk("par head kept", rx_data2, 8'h3C);

    // ---- TX single byte 0xA5
    txq.delete();
    tx_data0 = 8'hA5;
    tx_push0 = 1'b1;
    @(negedge clk);
    tx_push0 = 1'b0;
    w = 0;
    while (tx0 !== 1'b0 && w < 20) begin @(negedge clk); w++; end
    chk("tx1 start seen", tx0, 0);
    chk("tx1 busy", tx_idle0, 0);
    len = 0;
    while (tx0 === 1'b0 && len < 300) begin @(negedge clk); len++; end
    chk("tx1 start length in 151..160", (len >= 151 && len <= 160), 1);
    t = len;
    while (tx_idle0 !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    chk("tx1 frame length in 1585..1605", (t >= 1585 && t <= 1605), 1);
    repeat (5) @(negedge clk);
    chk("tx1 frames", txq.size(), 1);
    if (txq.size() > 0) chk("tx1 data+stop", txq[0], 9'h1A5);
    txq.delete();

    // ---- TX burst of 20 pushes
    for (int i = 0; i < 20; i++) begin
      tx_data0 = 8'(i + 1);
      tx_push0 = 1'b1;
      @(negedge clk);
      chk($sformatf("burst tx_full after push %0d", i + 1), tx_full0, i >= 16);
    end
    tx_push0 = 1'b0;
    chk("burst tx_count", tx_count0, 16);
    w = 0;
    while (txq.size() < 17 && w < 30000) begin @(negedge clk); w++; end
    chk("burst frames", txq.size(), 17);
    for (int i = 0; i < 17 && i < txq.size(); i++)
      chk($sformatf("burst byte %0d", i), txq[i], {1'b1, 8'(i + 1)});
    w = 0;
    while (tx_idle0 !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    chk("burst idle", tx_idle0, 1);

    // ---- reset in the middle of a TX and an RX frame
    tx_data0 = 8'h00;
    tx_push0 = 1'b1;
    @(negedge clk);
    tx_push0 = 1'b0;
    repeat (20) @(negedge clk);
    rx0 = 1'b0;
    repeat (BITC) @(negedge clk);
    rx0 = 1'b1;
    repeat (150) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst tx_stream", tx0, 1);
    chk("midrst tx_idle", tx_idle0, 1);
    chk("midrst tx_count", tx_count0, 0);
    chk("midrst rx_valid", rx_valid0, 0);
    repeat (2000) @(negedge clk);
    chk("midrst rx_count later", rx_count0, 0);
    chk("midrst frame_err later", rx_ferr0, 0);
    chk("midrst line idle later", tx0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_fifo_link.md
Name: uart_fifo_link

Overview:
Parametrised successor of the current UART pair. It contains a 16x-oversampled receiver with glitch rejection and framing/parity checks, a transmitter, and a synchronous FIFO on each direction in place of single-byte flag buffers. The crypter side pops RX bytes and pushes TX bytes. It sits between the XDC-bound serial pins and the crypter.

Parameters:
CLK_FREQ, 100000000, system clock in Hz.
BAUD_RATE, 19200, line rate. Simulation uses 625000.
DATA_BITS, 8, bits per character, legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of TX stop bits (1 or 2). RX always checks exactly one stop bit.
FIFO_DEPTH, 16, entries per FIFO. Must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_stream  in  1  serial input, asynchronous, idle high
tx_stream  out  1  serial output, idle high
rx_pop  in  1  consume the RX FIFO head
rx_valid  out  1  RX FIFO not empty
rx_data  out  DATA_BITS  RX FIFO head (show-ahead)
rx_count  out  $clog2(FIFO_DEPTH)+1  RX occupancy
rx_overrun  out  1  sticky: a byte was dropped because the FIFO was full
rx_frame_err  out  1  sticky: a bad stop bit or bad parity was seen
err_clear  in  1  clears both sticky flags
tx_push  in  1  write tx_data into the TX FIFO
tx_data  in  DATA_BITS  byte to send
tx_full  out  1  TX FIFO full
tx_count  out  $clog2(FIFO_DEPTH)+1  TX occupancy
tx_idle  out  1  TX FIFO empty, FSM in IDLE, and line idle

Behaviour:
- Reset, applied on any cycle including mid-frame:
  - tx_stream=1, rx_valid=0, both counts 0, tx_full=0, tx_idle=1, both error flags 0.
  - Both FSMs go to IDLE. The RX synchroniser flops are preset to 1.
  - A frame in progress is abandoned; no partial byte is stored.
- Tick generator: DIV=CLK_FREQ/(BAUD_RATE*16), integer-truncated and at least 1. One-cycle baud_tick every DIV clocks; the counter wraps to 0 on tick.
- RX path:
  - rx_stream passes a 2-flop synchroniser.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP, all counted in ticks.
  - IDLE to START when the synchronised line is low on a tick. Sample counter is cleared.
  - START: at tick 7 (mid-bit), a high line is a glitch and returns to IDLE with nothing stored. A low line clears the counter and goes to DATA.
  - DATA: sample every 16th tick, LSB first, DATA_BITS times. Then go to PARITY if PARITY!=0, else to STOP.
  - PARITY: sample once. A mismatch marks the frame bad.
  - STOP: sample once. A sampled 0 or a bad parity sets rx_frame_err and the byte is discarded. Otherwise the byte is pushed. The FSM returns to IDLE right after the stop sample, giving half-bit resync margin.
  - A push when full (no pop in the same cycle) is dropped, sets rx_overrun, and keeps the FIFO contents.
- FIFO rules, both FIFOs:
  - Read and write pointers carry an extra wrap bit.
  - Push and pop in the same cycle: both take effect and the count is unchanged.
  - The full condition is waived when a pop happens in the same cycle.
  - A pop when empty is ignored. A push when full without a pop is ignored and does not corrupt the head.
  - Data written is visible at the head one cycle after the push.
- Error flags: err_clear in the same cycle as a new error leaves the flag set, because set wins.
- TX path:
  - TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE with the FIFO non-empty, the FSM pops the head into the shift register on that cycle. tx_stream goes low on the next cycle.
  - Every bit lasts 16 ticks. The first bit may be short by less than one tick period.
  - DATA is sent LSB first. The PARITY state is skipped when PARITY=0. STOP lasts 16*STOP_BITS ticks.
  - After STOP the FSM returns to IDLE. If the FIFO is non-empty it pops again with no extra idle bit.
- Parity: odd parity means data bits XOR parity bit = 1. Even parity means it = 0.

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds an input port loopback (1 bit). When loopback=1, the RX synchroniser input is driven by the internal TX serial line and tx_stream is held at 1. Switching loopback during a frame gives undefined data but must not hang either FSM.
- Undefined: the port is absent and RX always uses rx_stream.

Test Plan:
All scenarios use CLK_FREQ=100 MHz, BAUD_RATE=625000 (DIV=10, 160 clocks/bit), DATA_BITS=8, PARITY=0, STOP_BITS=1, FIFO_DEPTH=16.
1. tx_push 0xA5 once -> tx_stream shows 0,1,0,1,0,0,1,0,1,1, each bit 160 clk (first bit may be up to 10 clk short). tx_idle=0 during the frame and returns to 1 after the stop bit.
2. Drive rx_stream with a frame for 0x3C at 1600 ns/bit -> rx_valid=1, rx_data=0x3C, rx_count=1. Then rx_pop -> rx_valid=0 next cycle.
3. Drive 17 frames with no pops -> rx_count=16, rx_overrun=1, rx_data=first byte. err_clear -> rx_overrun=0.
4. Drive a frame with stop bit 0 -> rx_frame_err=1 and rx_count unchanged. Repeat with PARITY=2 and a wrong parity bit -> same response.
5. 400 ns low pulse on an idle rx_stream -> no byte stored and no error flag; the next valid frame is received correctly.
6. tx_push asserted for 20 consecutive cycles with data 1..20 -> exactly 17 bytes accepted (values 1..17), tx_full=1 from the 17th push, and the serial output is 1..17 in order.
